// File: rtl/req_arbiter_4_if.sv
// Handshake bundle between the request arbiter and its requesters / downstream encoder.
// master drives requests and acknowledges; slave is the arbiter side.
interface req_arbiter_4_if;
  logic [3:0] req;
  logic       ack;
  logic       en;
  logic [3:0] y;
  logic [3:0] pending;
  logic       timeout_err;

  modport master (
    output req,
    output ack,
    input  en,
    input  y,
    input  pending,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  ack,
    output en,
    output y,
    output pending,
    output timeout_err
  );
endinterface

// File: rtl/req_arbiter_4.sv
// Round-robin arbiter: sticky pending flags issued one at a time as a registered one-hot grant,
// with an ack handshake and a grant-cycle watchdog that aborts unacknowledged grants.
module req_arbiter_4 #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  req_arbiter_4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         last_idx_q, last_idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         pending_q, pending_d;
  logic [3:0]         y_q, y_d;
  logic               en_q, en_d;
  logic               timeout_err_q, timeout_err_d;

  logic [1:0]         sel_idx;
  logic               sel_found;
  logic [1:0]         cand;
  logic               timeout_hit;
  logic [3:0]         clr;

  // Search starts just after the last granted index so it is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_idx_q;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_idx_q + 2'(i);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign clr         = ((state_q == GRANT) && bus.ack) ? y_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_idx_q    <= 2'd3;
      sel_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= '0;
      y_q           <= '0;
      en_q          <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_idx_q    <= last_idx_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      y_q           <= y_d;
      en_q          <= en_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = GRANT;
      GRANT:   if (bus.ack || timeout_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next registered outputs; ack takes priority over the timeout abort.
  always_comb begin
    pending_d     = (pending_q & ~clr) | bus.req;
    en_d          = en_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    last_idx_d    = last_idx_q;
    sel_d         = sel_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          y_d   = 4'b0001 << sel_idx;
          en_d  = 1'b1;
          cnt_d = '0;
          sel_d = sel_idx;
        end else begin
          y_d  = '0;
          en_d = 1'b0;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          en_d       = 1'b0;
          y_d        = '0;
          last_idx_d = sel_q;
        end else if (timeout_hit) begin
          en_d          = 1'b0;
          y_d           = '0;
          last_idx_d    = sel_q;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        en_d = 1'b0;
        y_d  = '0;
      end
      default: begin
        en_d = 1'b0;
        y_d  = '0;
      end
    endcase
  end

  assign bus.en          = en_q;
  assign bus.y           = y_q;
  assign bus.pending     = pending_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/req_arbiter_4.md
Name: req_arbiter_4

Overview:
- Upstream stage for the 4:2 encoder.
- Collects four independent request lines into sticky pending flags and issues them one at a time as a registered one-hot word `y[3:0]` qualified by `en`, in round-robin order.
- The downstream consumer (the encoder plus its sink) returns `ack` when the current code has been taken.
- A grant cycle counter aborts grants that are never acknowledged.

Parameters:
- TIMEOUT, 15: max GRANT cycles without ack before abort; legal range 2..255.
- CNT_W, 8: grant counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous reset, active-high
- req  input  4  request lines; sampled every clk edge, level or pulse
- ack  input  1  consumer accepted current grant; only meaningful in GRANT
- en  output  1  grant valid; encoder enable
- y  output  4  one-hot grant word; 4'b0000 whenever en=0
- pending  output  4  sticky request flags, registered
- timeout_err  output  1  one-cycle pulse on grant abort

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values, applied on any edge with rst=1, including mid-grant:
  - outputs: en=0, y=0, pending=0, timeout_err=0
  - internal: state=IDLE, last_idx=2'd3, cnt=0
  - Everything in flight is discarded.
- Pending update, every edge: pending <= (pending & ~clr) | req.
  - clr = y when state=GRANT and ack=1; otherwise 0.
  - If req sets the same bit being cleared, set wins and the bit stays 1.
- Selection: search indices last_idx+1, +2, +3, +4 (mod 4) and take the first with pending=1.
  - Reset value last_idx=3 means the first search starts at bit 0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: en=0, y=0.
  - If pending != 0: next edge loads y = one-hot(selected), en=1, cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: y and en held constant.
  - If ack=1: next edge clears pending[sel], sets last_idx=sel, en=0, y=0, go to RELEASE.
  - Else if cnt==TIMEOUT-1: next edge sets en=0, y=0, timeout_err=1, last_idx=sel, pending[sel] kept, go to RELEASE.
  - Else cnt <= cnt+1.
  - ack on the same cycle as the timeout condition: ack wins and no timeout_err is raised.
- RELEASE: en=0 for exactly one cycle; timeout_err drops back to 0; go to IDLE unconditionally.
  - This guarantees at least one en=0 cycle between consecutive grants.
- Latency:
  - req high at edge k is visible in pending after edge k.
  - Earliest en=1 is after edge k+1, provided the FSM is in IDLE.
  - Consecutive serviced grants are at least 3 cycles apart (GRANT with immediate ack, RELEASE, IDLE).
- Fairness:
  - An index that was granted (acked or aborted) is searched last on the next selection.
  - An aborted index re-requests automatically because its pending flag is still set.
- Ignored inputs: ack in IDLE or RELEASE has no effect. req in any state only updates pending.
- Grant width: y always carries at most one bit set; y=0 is equivalent to en=0.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with req=4'b1111.
  - Required: en=0, y=0, pending=0.
  - After release with req=0: pending stays 0 and en stays 0.
- Single request: pulse req=4'b0100 for one cycle, ack one cycle after en rises.
  - Required: pending=4'b0100 after the first edge; en=1, y=4'b0100 after the second edge.
  - After the ack edge: pending=0, en=0; FSM returns to IDLE.
- Round-robin: load pending=4'b1111, ack every grant immediately.
  - Required: y sequence 0001, 0010, 0100, 1000, with en=0 for ≥2 cycles between grants.
  - Repeat with pending=4'b1001 after last_idx=0: order must be 1000, then 0001.
- Timeout: req=4'b0010 once, never ack, TIMEOUT=15.
  - Required: en high exactly 15 cycles, then timeout_err=1 for 1 cycle, pending stays 4'b0010.
  - Regrant of 0010 occurs 2 cycles after en falls.
  - Second variant: ack asserted on cnt=14 gives a clean clear and no timeout_err.
- Simultaneous set/clear: during GRANT of 0001, drive ack=1 and req=4'b0001 on the same edge.
  - Required: pending[0] remains 1; 0001 is granted again after the other pending bits per round-robin.
- Reset mid-grant: assert rst while en=1, y=4'b1000, pending=4'b1010.
  - Required: next edge gives en=0, y=0, pending=0; the first grant after reset for req=4'b1111 is 0001.
